// File: rtl/img_sram_arbiter_if.sv
// Bus bundle linking the requester controllers, the round-robin arbiter and the
// shared img_sram macro. Field semantics follow img_sram_ctrl_t, flattened.
interface img_sram_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int ROW_W = 8,
  parameter int COL_W = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       gnt;
  logic [NREQ*8-1:0]     req_din;
  logic [NREQ*ROW_W-1:0] req_row;
  logic [NREQ*COL_W-1:0] req_col;
  logic [NREQ-1:0]       req_write_en;
  logic [NREQ-1:0]       req_sense_en;
  logic [7:0]            sram_din;
  logic [ROW_W-1:0]      sram_row;
  logic [COL_W-1:0]      sram_col;
  logic                  sram_write_en;
  logic                  sram_sense_en;
  logic [7:0]            sram_dout;
  logic [7:0]            rd_data;
  logic [NREQ-1:0]       rd_valid;
  logic                  busy;

  modport master (
    output req, req_din, req_row, req_col, req_write_en, req_sense_en, sram_dout,
    input  gnt, sram_din, sram_row, sram_col, sram_write_en, sram_sense_en,
           rd_data, rd_valid, busy
  );

  modport slave (
    input  req, req_din, req_row, req_col, req_write_en, req_sense_en, sram_dout,
    output gnt, sram_din, sram_row, sram_col, sram_write_en, sram_sense_en,
           rd_data, rd_valid, busy
  );
endinterface

// File: rtl/img_sram_arbiter.sv
// Round-robin owner arbiter for one img_sram macro: registered one-hot grant,
// optional burst limit, and 1-cycle read-data return steered to the issuer.
module img_sram_arbiter #(
  parameter int NREQ      = 3,
  parameter int ROW_W     = 8,
  parameter int COL_W     = 8,
  parameter int MAX_BURST = 64
) (
  input logic               clk,
  input logic               rst,
  img_sram_arbiter_if.slave io_bus
);
  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NREQ - 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_rd_data_p1;
  logic [NREQ-1:0]  r_rd_valid_p1;

  logic [NREQ-1:0]  w_active;
  logic [NREQ-1:0]  w_rd_issue;
  logic [PTR_W-1:0] w_owner;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W-1:0] w_idx;
  logic             w_pick_found;
  logic             w_others_wait;
  logic             w_at_limit;

  assign w_active      = r_gnt & io_bus.req;
  assign w_rd_issue    = w_active & io_bus.req_sense_en & ~io_bus.req_write_en;
  assign w_others_wait = |(io_bus.req & ~r_gnt);
  assign w_at_limit    = (MAX_BURST != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) w_owner = PTR_W'(i);
    end
  end

  // Circular search starting just after the last owner, so it is served last.
  always_comb begin
    w_pick       = r_ptr;
    w_idx        = r_ptr;
    w_pick_found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      w_idx = PTR_W'((int'(r_ptr) + off) % NREQ);
      if (!w_pick_found && io_bus.req[w_idx]) begin
        w_pick       = w_idx;
        w_pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= PTR_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (|io_bus.req) begin
          w_gnt_nxt         = '0;
          w_gnt_nxt[w_pick] = 1'b1;
          w_state_nxt       = S_OWN;
        end
      end
      S_OWN: begin
        if (!io_bus.req[w_owner] || (w_at_limit && w_others_wait)) begin
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_owner;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (!w_at_limit) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Only an active owner reaches the SRAM; everything else sees the hold pattern.
  always_comb begin
    io_bus.sram_din      = '0;
    io_bus.sram_row      = '0;
    io_bus.sram_col      = '0;
    io_bus.sram_write_en = 1'b0;
    io_bus.sram_sense_en = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (w_active[i]) begin
        io_bus.sram_din      = io_bus.req_din[8*i +: 8];
        io_bus.sram_row      = io_bus.req_row[ROW_W*i +: ROW_W];
        io_bus.sram_col      = io_bus.req_col[COL_W*i +: COL_W];
        io_bus.sram_write_en = io_bus.req_write_en[i];
        io_bus.sram_sense_en = io_bus.req_sense_en[i];
      end
    end
  end

  // p0 -> p1: capture read data at the edge ending the read cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid_p1 <= '0;
      r_rd_data_p1  <= '0;
    end else begin
      r_rd_valid_p1 <= w_rd_issue;
      if (|w_rd_issue) r_rd_data_p1 <= io_bus.sram_dout;
    end
  end

  assign io_bus.gnt      = r_gnt;
  assign io_bus.busy     = |r_gnt;
  assign io_bus.rd_data  = r_rd_data_p1;
  assign io_bus.rd_valid = r_rd_valid_p1;
endmodule

// File: tb/tb_img_sram_arbiter.sv
// Directed bench for img_sram_arbiter: one instance with the default burst limit
// and one with MAX_BURST=4; the SRAM model returns the row index as read data.
module tb_img_sram_arbiter;
  localparam int NREQ  = 3;
  localparam int ROW_W = 8;
  localparam int COL_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  img_sram_arbiter_if #(.NREQ(NREQ), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();
  img_sram_arbiter_if #(.NREQ(NREQ), .ROW_W(ROW_W), .COL_W(COL_W)) bus_b ();

  img_sram_arbiter #(.NREQ(NREQ), .ROW_W(ROW_W), .COL_W(COL_W), .MAX_BURST(64)) dut (
    .clk(clk), .rst(rst), .io_bus(bus)
  );
  img_sram_arbiter #(.NREQ(NREQ), .ROW_W(ROW_W), .COL_W(COL_W), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst(rst), .io_bus(bus_b)
  );

  assign bus.sram_dout   = bus.sram_row;
  assign bus_b.sram_dout = 8'h00;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.req = '0;   bus.req_din = '0;   bus.req_row = '0;   bus.req_col = '0;
    bus.req_write_en = '0;   bus.req_sense_en = '0;
    bus_b.req = '0; bus_b.req_din = '0; bus_b.req_row = '0; bus_b.req_col = '0;
    bus_b.req_write_en = '0; bus_b.req_sense_en = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (bus.gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt: got %b want 000", bus.gnt); end
    n_vec++; if (bus.rd_valid !== 3'b000) begin n_err++; $display("FAIL rst_rd_valid: got %b want 000", bus.rd_valid); end
    n_vec++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data: got %h want 00", bus.rd_data); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.sram_sense_en !== 1'b1) begin n_err++; $display("FAIL rst_hold_sense: got %b want 1", bus.sram_sense_en); end
    n_vec++; if (bus.sram_write_en !== 1'b0) begin n_err++; $display("FAIL rst_hold_write: got %b want 0", bus.sram_write_en); end
    n_vec++; if (bus_b.gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt_b: got %b want 000", bus_b.gnt); end
  endtask

  task automatic test_basic_write();
    apply_reset();
    bus.req_row[7:0] = 8'd5;
    bus.req_col[7:0] = 8'd7;
    bus.req_din[7:0] = 8'hA5;
    bus.req_write_en[0] = 1'b1;
    bus.req = 3'b001;
    settle();
    n_vec++; if (bus.gnt !== 3'b000) begin n_err++; $display("FAIL basic_pre_gnt: got %b want 000", bus.gnt); end
    n_vec++; if (bus.sram_write_en !== 1'b0) begin n_err++; $display("FAIL basic_pre_write: got %b want 0", bus.sram_write_en); end
    tick();
    n_vec++; if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL basic_gnt: got %b want 001", bus.gnt); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    n_vec++; if (bus.sram_row !== 8'd5) begin n_err++; $display("FAIL basic_row: got %0d want 5", bus.sram_row); end
    n_vec++; if (bus.sram_col !== 8'd7) begin n_err++; $display("FAIL basic_col: got %0d want 7", bus.sram_col); end
    n_vec++; if (bus.sram_din !== 8'hA5) begin n_err++; $display("FAIL basic_din: got %h want a5", bus.sram_din); end
    n_vec++; if (bus.sram_write_en !== 1'b1) begin n_err++; $display("FAIL basic_write: got %b want 1", bus.sram_write_en); end
    n_vec++; if (bus.sram_sense_en !== 1'b0) begin n_err++; $display("FAIL basic_sense: got %b want 0", bus.sram_sense_en); end
    tick();
    n_vec++; if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL basic_gnt2: got %b want 001", bus.gnt); end
    bus.req = 3'b000;
    settle();
    n_vec++; if (bus.sram_row !== 8'd0) begin n_err++; $display("FAIL basic_rel_row: got %0d want 0", bus.sram_row); end
    n_vec++; if (bus.sram_din !== 8'h00) begin n_err++; $display("FAIL basic_rel_din: got %h want 00", bus.sram_din); end
    n_vec++; if (bus.sram_write_en !== 1'b0) begin n_err++; $display("FAIL basic_rel_write: got %b want 0", bus.sram_write_en); end
    n_vec++; if (bus.sram_sense_en !== 1'b1) begin n_err++; $display("FAIL basic_rel_sense: got %b want 1", bus.sram_sense_en); end
    n_vec++; if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL basic_rel_gnt: got %b want 001", bus.gnt); end
    tick();
    n_vec++; if (bus.gnt !== 3'b000) begin n_err++; $display("FAIL basic_after_gnt: got %b want 000", bus.gnt); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_after_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 2, 0};
    logic [2:0] exp_g;
    apply_reset();
    for (int k = 0; k < NREQ; k++) bus.req_row[8*k +: 8] = 8'(10 + k);
    bus.req = 3'b111;
    settle();
    n_vec++; if (bus.gnt !== 3'b000) begin n_err++; $display("FAIL rr_start_gnt: got %b want 000", bus.gnt); end
    tick();
    for (int n = 0; n < 4; n++) begin
      exp_g = 3'(1 << order[n]);
      for (int c = 0; c < 4; c++) begin
        n_vec++; if (bus.gnt !== exp_g) begin n_err++; $display("FAIL rr_gnt_%0d_%0d: got %b want %b", n, c, bus.gnt, exp_g); end
        n_vec++; if (bus.sram_row !== 8'(10 + order[n])) begin n_err++; $display("FAIL rr_row_%0d_%0d: got %0d want %0d", n, c, bus.sram_row, 10 + order[n]); end
        tick();
      end
      bus.req[order[n]] = 1'b0;
      settle();
      n_vec++; if (bus.sram_row !== 8'd0) begin n_err++; $display("FAIL rr_rel_row_%0d: got %0d want 0", n, bus.sram_row); end
      tick();
      n_vec++; if (bus.gnt !== 3'b000) begin n_err++; $display("FAIL rr_hold_gnt_%0d: got %b want 000", n, bus.gnt); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rr_hold_busy_%0d: got %b want 0", n, bus.busy); end
      bus.req = 3'b111;
      tick();
    end
    bus.req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_burst_limit();
    apply_reset();
    bus_b.req_row[15:8] = 8'h21;
    bus_b.req = 3'b001;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) bus_b.req[1] = 1'b1;
      n_vec++; if (bus_b.gnt !== 3'b001) begin n_err++; $display("FAIL burst_own0_c%0d: got %b want 001", c, bus_b.gnt); end
      tick();
    end
    n_vec++; if (bus_b.gnt !== 3'b000) begin n_err++; $display("FAIL burst_preempt: got %b want 000", bus_b.gnt); end
    tick();
    n_vec++; if (bus_b.gnt !== 3'b010) begin n_err++; $display("FAIL burst_gnt1: got %b want 010", bus_b.gnt); end
    n_vec++; if (bus_b.sram_row !== 8'h21) begin n_err++; $display("FAIL burst_row1: got %h want 21", bus_b.sram_row); end
    tick();
    n_vec++; if (bus_b.gnt !== 3'b010) begin n_err++; $display("FAIL burst_gnt1_b: got %b want 010", bus_b.gnt); end
    tick();
    bus_b.req[1] = 1'b0;
    settle();
    n_vec++; if (bus_b.sram_row !== 8'h00) begin n_err++; $display("FAIL burst_rel_row: got %h want 00", bus_b.sram_row); end
    tick();
    n_vec++; if (bus_b.gnt !== 3'b000) begin n_err++; $display("FAIL burst_rel_gnt: got %b want 000", bus_b.gnt); end
    tick();
    for (int c = 0; c < 12; c++) begin
      n_vec++; if (bus_b.gnt !== 3'b001) begin n_err++; $display("FAIL burst_solo_c%0d: got %b want 001", c, bus_b.gnt); end
      tick();
    end
    bus_b.req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_back_to_back_reads();
    apply_reset();
    bus.req_sense_en[2] = 1'b1;
    bus.req_row[23:16] = 8'd0;
    bus.req = 3'b100;
    tick();
    n_vec++; if (bus.gnt !== 3'b100) begin n_err++; $display("FAIL rd_gnt: got %b want 100", bus.gnt); end
    n_vec++; if (bus.rd_valid !== 3'b000) begin n_err++; $display("FAIL rd_pre_valid: got %b want 000", bus.rd_valid); end
    for (int r = 0; r < 4; r++) begin
      bus.req_row[23:16] = 8'(r);
      tick();
      n_vec++; if (bus.rd_valid !== 3'b100) begin n_err++; $display("FAIL rd_valid_%0d: got %b want 100", r, bus.rd_valid); end
      n_vec++; if (bus.rd_data !== 8'(r)) begin n_err++; $display("FAIL rd_data_%0d: got %0d want %0d", r, bus.rd_data, r); end
    end
    bus.req_sense_en[2] = 1'b0;
    bus.req_write_en[2] = 1'b1;
    bus.req_row[23:16] = 8'd9;
    bus.req_din[23:16] = 8'h3C;
    settle();
    n_vec++; if (bus.sram_din !== 8'h3C) begin n_err++; $display("FAIL wr_din: got %h want 3c", bus.sram_din); end
    n_vec++; if (bus.sram_write_en !== 1'b1) begin n_err++; $display("FAIL wr_en: got %b want 1", bus.sram_write_en); end
    tick();
    n_vec++; if (bus.rd_valid !== 3'b000) begin n_err++; $display("FAIL wr_rd_valid: got %b want 000", bus.rd_valid); end
    bus.req_sense_en[2] = 1'b1;
    settle();
    n_vec++; if (bus.sram_write_en !== 1'b1 || bus.sram_sense_en !== 1'b1) begin
      n_err++; $display("FAIL wr_both: got we=%b se=%b want we=1 se=1", bus.sram_write_en, bus.sram_sense_en);
    end
    tick();
    n_vec++; if (bus.rd_valid !== 3'b000) begin n_err++; $display("FAIL wr_both_rd_valid: got %b want 000", bus.rd_valid); end
    bus.req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    bus.req_row[7:0] = 8'd3;
    bus.req_sense_en[0] = 1'b1;
    bus.req = 3'b001;
    tick();
    n_vec++; if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL mid_gnt: got %b want 001", bus.gnt); end
    rst = 1'b1;
    bus.req = 3'b111;
    tick();
    n_vec++; if (bus.gnt !== 3'b000) begin n_err++; $display("FAIL mid_rst_gnt: got %b want 000", bus.gnt); end
    n_vec++; if (bus.rd_valid !== 3'b000) begin n_err++; $display("FAIL mid_rst_rd_valid: got %b want 000", bus.rd_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.sram_row !== 8'd0 || bus.sram_sense_en !== 1'b1 || bus.sram_write_en !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_hold: got row=%0d se=%b we=%b want row=0 se=1 we=0", bus.sram_row, bus.sram_sense_en, bus.sram_write_en);
    end
    rst = 1'b0;
    tick();
    n_vec++; if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL mid_first_winner: got %b want 001", bus.gnt); end
    bus.req = 3'b000;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_write();
    test_round_robin();
    test_burst_limit();
    test_back_to_back_reads();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/img_sram_arbiter.md
Name: img_sram_arbiter

Overview:
- Round-robin arbiter that shares one img_sram macro between NREQ requester controllers (IO rx/tx, row convolution, future blocks).
- Replaces per-opcode static muxing so that several controllers can interleave accesses to one SRAM.
- Registers ownership grants, enforces an optional burst limit, and steers 1-cycle-latency read data back to the issuing requester.
- The SRAM interface is flattened; field semantics match img_sram_ctrl_t.

Parameters:
NREQ, 3, number of requesters (2..8)
ROW_W, 8, SRAM row address width
COL_W, 8, SRAM column address width
MAX_BURST, 64, maximum consecutive owned cycles while another requester waits; 0 = unlimited

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
req  input  NREQ  per-requester ownership request; level, held for the whole burst
gnt  output  NREQ  registered one-hot grant; at most one bit set
req_din  input  NREQ*8  per-requester write data, packed, requester i at [8i+:8]
req_row  input  NREQ*ROW_W  per-requester row address
req_col  input  NREQ*COL_W  per-requester column address
req_write_en  input  NREQ  per-requester write enable
req_sense_en  input  NREQ  per-requester sense/read enable
sram_din  output  8  to SRAM
sram_row  output  ROW_W  to SRAM
sram_col  output  COL_W  to SRAM
sram_write_en  output  1  to SRAM
sram_sense_en  output  1  to SRAM
sram_dout  input  8  SRAM read data, valid 1 cycle after the read cycle
rd_data  output  8  registered copy of sram_dout, broadcast to all requesters
rd_valid  output  NREQ  one-hot; rd_data belongs to requester i
busy  output  1  any gnt bit set

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - gnt=0, rd_valid=0, rd_data=0, busy=0.
  - Burst counter = 0.
  - Last-owner pointer = NREQ-1, so requester 0 wins first.
- Hold state: sram_din=0, row=0, col=0, write_en=0, sense_en=1. SRAM outputs are in hold whenever no requester is "active".
  - Active means gnt[i] & req[i].
  - Outputs are combinational from the gnt register and req. A released or preempted owner never drives the SRAM.
- FSM states:
  - IDLE (gnt=0): if any req, choose the first requester set after the last-owner pointer, circular. Set its gnt bit at the next edge; next state OWN.
  - OWN (gnt[k]=1): SRAM fields = requester k's fields; burst counter increments each cycle.
    - Release: req[k]=0. Outputs go to hold in that same cycle; gnt=0 at the next edge; next state IDLE. This gives one hold cycle between owners, which is required for handover.
    - Preempt: MAX_BURST!=0, counter == MAX_BURST-1, and any other req set. Drop gnt at the next edge, pointer=k, next state IDLE. The owner must stall while gnt=0 and keep req high to re-enter arbitration.
    - If no other req is set, the counter saturates at MAX_BURST-1 and ownership continues.
  - Counter clears on every transition to IDLE.
- Pointer updates to k on release or preempt. A new grant never goes to k while another requester is waiting.
- Read return:
  - Read cycle = active & sense_en & !write_en.
  - At the next edge: rd_data<=sram_dout, rd_valid<=one-hot of the issuer; otherwise rd_valid<=0.
  - Reads issued in the last owned cycle still return, even though gnt has dropped.
- Write cycle: active & write_en; fields are passed through unchanged. write_en and sense_en both high is passed through; the SRAM defines the result.
- req asserted by a non-owner while OWN: no effect until arbitration.
- Reset mid-burst: outputs are in hold from the first cycle after the rst edge, and pending rd_valid is dropped.
- Width rules: all fields are passed through unmodified. The counter is clog2(MAX_BURST)+1 bits. No arithmetic on addresses.

Test Plan:
- Reset, then req=3'b001 with row=5, col=7, write_en, din=0xA5 → gnt=001 at cycle+1; sram_row=5, col=7, din=A5, write_en=1 while active; after req drops, hold fields the same cycle and gnt=000 next cycle.
- req=3'b111 held, each owner releases after 4 cycles → grant order 0,1,2,0; exactly one hold cycle between owners; busy low only in hold/IDLE cycles.
- MAX_BURST=4, req0 held continuously, req1 raised at cycle 2 → gnt0 dropped after 4 owned cycles, gnt1 granted, then gnt0 again after req1 releases; with req0 alone, gnt0 never drops.
- Requester 2 reads rows 0..3 back-to-back with the SRAM model returning row index → rd_valid=100 on 4 consecutive cycles one cycle after each read, rd_data=0,1,2,3; rd_valid=0 for write cycles.
- rst asserted mid-burst with a read outstanding → next cycle gnt=0, rd_valid=0, SRAM fields in hold; after reset, requester 0 wins first despite all req high.
